// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV immediate decoder (I/S/B/U/J) feeding a 2-entry skid-buffered valid/ready stage.
// Optional define IMM_GEN_CSR_EN maps ImmSrc 101 to the zero-extended CSR uimm (instr[19:15]).
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      instruction,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic              main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;

    logic [31:0]       w_imm32;
    logic              w_sext;
    logic              w_illegal;
    logic [XLEN-1:0]   w_imm;
    logic              w_accept;
    logic              w_deliver;
    logic              w_unused_opcode;

    // Opcode bits never contribute to any immediate.
    assign w_unused_opcode = &{1'b0, instruction[6:0]};

    always_comb begin
        w_imm32   = '0;
        w_sext    = 1'b1;
        w_illegal = 1'b0;
        case (ImmSrc)
            3'b000: w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            3'b001: w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            3'b010: w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                               instruction[30:25], instruction[11:8], 1'b0};
            3'b011: w_imm32 = {instruction[31:12], 12'b0};
            3'b100: w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                               instruction[20], instruction[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
            3'b101: begin
                w_imm32 = {27'b0, instruction[19:15]};
                w_sext  = 1'b0;
            end
`endif
            default: begin
                w_imm32   = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_sext & w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    assign in_ready    = (state_q != TWO);
    assign out_valid   = (state_q != EMPTY);
    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    state_d    = ONE;
                    main_imm_d = w_imm;
                    main_tag_d = in_tag;
                    main_ill_d = w_illegal;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    main_imm_d = w_imm;
                    main_tag_d = in_tag;
                    main_ill_d = w_illegal;
                end else if (w_deliver) begin
                    state_d = EMPTY;
                end else if (w_accept) begin
                    state_d    = TWO;
                    skid_imm_d = w_imm;
                    skid_tag_d = in_tag;
                    skid_ill_d = w_illegal;
                end
            end
            TWO: begin
                if (w_deliver) begin
                    state_d    = ONE;
                    main_imm_d = skid_imm_q;
                    main_tag_d = skid_tag_q;
                    main_ill_d = skid_ill_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only kills occupancy; stale payload is never visible without a valid.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator: decodes all five RV base immediate formats (I, S, B, U, J) and sign-extends to a parametrised XLEN.
- Registered stage with valid/ready handshake and a 2-entry skid buffer, so it can sit between fetch/decode and the execute-stage operand mux without breaking the ready path.
- Each instruction carries an opaque tag (PC or uop ID) alongside its immediate.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; drops all buffered entries
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept; equals !skid_valid (registered source)
- ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 unsupported
- instruction  input  32  raw instruction word
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  out_imm/out_tag/out_illegal valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the instruction in out_imm
- out_illegal  output  1  ImmSrc was unsupported

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Decode, combinational before the main register; sign bit is always instruction[31]:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: sext({instr[31:12], 12'b0})
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - Unsupported codes: imm = 0, illegal = 1.
- Extension is to full XLEN, so upper 32 bits on XLEN=64 all equal instr[31], U format included.
- Storage: main register (drives outputs) plus skid register; each holds {imm, tag, illegal, valid}.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- States by occupancy:
  - EMPTY: accept -> ONE.
  - ONE, no accept, deliver -> EMPTY.
  - ONE, accept, deliver -> ONE; new entry in main.
  - ONE, accept, no deliver -> TWO; new entry in skid.
  - TWO: in_ready = 0; deliver -> ONE; skid moves to main.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1/cycle under continuous out_ready.
- Ordering is strictly FIFO; a skid entry is never presented before the main entry.
- Outputs are stable while out_valid && !out_ready.
- flush: next cycle both valids = 0 and in_ready = 1. An accept in the flush cycle is discarded. flush has priority over accept and deliver.
- reset: out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, skid cleared, in_ready = 1 from the first cycle after reset. Inputs during reset are ignored.
- Reset or flush mid-backpressure loses both entries; no partial state survives.

Optional Feature:
- Macro: IMM_GEN_CSR_EN.
- Defined:
  - ImmSrc 101 selects the CSR uimm: zext(instr[19:15]) to XLEN, out_illegal = 0.
  - Only 110-111 are unsupported.
- Undefined: 101 is unsupported (imm 0, illegal 1). No other behaviour changes.

Test Plan:
- I-type 0xFFF00093, ImmSrc 000, out_ready 1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- Format sweep, XLEN=32:
  - S 0xFE512E23 -> 0xFFFFFFFC
  - B 0xFE000CE3 -> 0xFFFFFFF8
  - U 0x123450B7 -> 0x12345000
  - J 0x001000EF -> 0x00000800
  - each with tag echoed.
- Backpressure: hold out_ready=0, push tags 1,2 on consecutive cycles -> in_ready=0 after 2nd accept. Release -> tags 1 then 2 on consecutive cycles, values unchanged, in_ready=1 again.
- Flush in TWO state while in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry ever delivered.
- XLEN=64, U 0x800000B7 -> out_imm=0xFFFFFFFF80000000. ImmSrc 111 -> out_imm=0, out_illegal=1.
- With IMM_GEN_CSR_EN, ImmSrc 101, instr[19:15]=5'b11111 -> out_imm=0x1F, out_illegal=0. Without it -> out_imm=0, out_illegal=1.
